// File: rtl/register_file_sort_ctrl.sv
// register_file_sort_ctrl
//   Drives a register_file_swap's swapxy/x/y inputs to sort its contents in
//   place with a bubble sort that stops early after a pass without swaps.
//   It compares one adjacent pair r[idx], r[idx+1] per cycle. An out-of-order
//   pair costs one extra cycle, during which swapxy is high and the register
//   file swaps at the closing edge. No compare reads r in the cycle a swap
//   commits.
//
// Build option: define SORT_DESCEND_EN to sort into descending order.
//   This does not change the ports or the timing.
//
// Ports
//   clk         in   rising-edge clock
//   init_n      in   asynchronous active-low reset
//   start       in   begin a sort; only honoured in IDLE
//   r           in   register file contents r[NREG-1:0]
//   swapxy      out  swap enable to the register file (registered)
//   x, y        out  swap indices, y = x+1 while swapxy=1 (registered, held)
//   busy        out  high while a sort is running
//   done        out  one-cycle completion pulse
//   swap_count  out  swaps issued in the current/last sort, saturating
module register_file_sort_ctrl #(
  parameter int NREG = 8,
  parameter int DW   = 4,
  parameter int IDXW = 3,
  parameter int CNTW = 6
) (
  input  logic                 clk,
  input  logic                 init_n,
  input  logic                 start,
  input  logic [DW-1:0]        r [NREG-1:0],
  output logic                 swapxy,
  output logic [IDXW-1:0]      x,
  output logic [IDXW-1:0]      y,
  output logic                 busy,
  output logic                 done,
  output logic [CNTW-1:0]      swap_count
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_SWAP, S_DONE} state_t;

  // Last pair index, and the last pass allowed (NREG-1 passes in total).
  localparam logic [IDXW-1:0] LAST = IDXW'(NREG - 2);

  state_t          r_state, w_nxt;
  logic [IDXW-1:0] r_idx, r_pass, r_x, r_y;
  logic            r_pass_swapped;
  logic [CNTW-1:0] r_cnt;
  logic            r_swapxy, r_busy, r_done;

  logic [IDXW-1:0] w_idx_p1;
  logic            w_ooo, w_last, w_last_pass, w_adv;
  logic            w_swapxy_d, w_busy_d, w_done_d;

  assign w_idx_p1    = r_idx + IDXW'(1);
  assign w_last      = (r_idx == LAST);
  assign w_last_pass = (r_pass == LAST);

`ifdef SORT_DESCEND_EN
  assign w_ooo = (r[r_idx] < r[w_idx_p1]);
`else
  assign w_ooo = (r[r_idx] > r[w_idx_p1]);
`endif

  // The current pair is resolved: either it compared in order, or its swap
  // is committing this cycle.
  assign w_adv = ((r_state == S_COMPARE) && !w_ooo) || (r_state == S_SWAP);

  // State register
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_COMPARE;
      S_COMPARE: begin
        if (w_ooo)
          w_nxt = S_SWAP;
        else if (w_last && (!r_pass_swapped || w_last_pass))
          w_nxt = S_DONE;
        else
          w_nxt = S_COMPARE;
      end
      // A pass that reaches its swap cycle has swapped, so only the pass
      // limit can end it here.
      S_SWAP:    w_nxt = (w_last && w_last_pass) ? S_DONE : S_COMPARE;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // Output logic: the next values of the registered outputs follow from the
  // state being entered.
  always_comb begin
    w_swapxy_d = (w_nxt == S_SWAP);
    w_busy_d   = (w_nxt == S_COMPARE) || (w_nxt == S_SWAP);
    w_done_d   = (w_nxt == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_idx          <= '0;
      r_pass         <= '0;
      r_pass_swapped <= 1'b0;
      r_cnt          <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_swapxy       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_swapxy <= w_swapxy_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;

      if (r_state == S_IDLE && start) begin
        r_idx          <= '0;
        r_pass         <= '0;
        r_pass_swapped <= 1'b0;
        r_cnt          <= '0;
      end

      if (r_state == S_COMPARE && w_ooo) begin
        r_x <= r_idx;
        r_y <= w_idx_p1;
      end

      if (r_state == S_SWAP) begin
        r_pass_swapped <= 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + CNTW'(1);
      end

      if (w_adv) begin
        if (!w_last) begin
          r_idx <= w_idx_p1;
        end else if (w_nxt == S_COMPARE) begin
          // Start the next pass; this overrides the swap flag set above.
          r_idx          <= '0;
          r_pass         <= r_pass + IDXW'(1);
          r_pass_swapped <= 1'b0;
        end
      end
    end
  end

  assign swapxy     = r_swapxy;
  assign x          = r_x;
  assign y          = r_y;
  assign busy       = r_busy;
  assign done       = r_done;
  assign swap_count = r_cnt;

endmodule

// File: tb/tb_register_file_sort_ctrl.sv
module tb_register_file_sort_ctrl;
  localparam int NREG = 8;
  localparam int DW   = 4;
  localparam int IDXW = 3;
  localparam int CNTW = 6;

  typedef logic [DW-1:0] arr_t [NREG-1:0];

  typedef struct {
    arr_t v;
    int   exp_cnt;
    int   exp_cyc;
    bit   use_model;
    int   p1;
    int   p2;
  } vec_t;

  logic            clk = 1'b0;
  logic            init_n = 1'b0;
  logic            start = 1'b0;
  arr_t            regs;
  logic            swapxy, busy, done;
  logic [IDXW-1:0] x, y;
  logic [CNTW-1:0] swap_count;

  logic            ld = 1'b0;
  arr_t            ld_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Downstream register file: swaps at the edge that closes a swapxy cycle.
  always @(posedge clk) begin
    if (ld) regs <= ld_val;
    else if (swapxy) begin
      regs[x] <= regs[y];
      regs[y] <= regs[x];
    end
  end

  register_file_sort_ctrl #(.NREG(NREG), .DW(DW), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk(clk), .init_n(init_n), .start(start), .r(regs),
    .swapxy(swapxy), .x(x), .y(y), .busy(busy), .done(done),
    .swap_count(swap_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit ooo(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SORT_DESCEND_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  // Nibble i of h becomes r[i].
  function automatic arr_t mk(input logic [31:0] h);
    arr_t a;
    for (int i = 0; i < NREG; i++) a[i] = h[4*i +: 4];
    return a;
  endfunction

  // Bubble sort with early exit: one cycle per compare, one per swap, then
  // the done cycle.
  function automatic void model(input arr_t a_in, output int cnt, output int cyc);
    arr_t a;
    int   cmp;
    bit   sw;
    logic [DW-1:0] t;
    a = a_in; cmp = 0; cnt = 0;
    for (int p = 0; p < NREG - 1; p++) begin
      sw = 0;
      for (int i = 0; i < NREG - 1; i++) begin
        cmp++;
        if (ooo(a[i], a[i+1])) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t;
          cnt++; sw = 1;
        end
      end
      if (!sw) break;
    end
    cyc = cmp + cnt + 1;
  endfunction

  task automatic load(input arr_t v);
    @(negedge clk);
    ld_val = v; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Loads v, starts a sort in cycle 0, optionally re-pulses start in cycles
  // p1/p2, and checks completion cycle, count and final order.
  task automatic run_vec(input string nm, input arr_t v, input int exp_cnt,
                         input int exp_cyc, input int p1, input int p2);
    logic [DW-1:0] q[$];
    int  c, bad;
    bit  seen;
    load(v);
    q.delete();
    for (int i = 0; i < NREG; i++) q.push_back(v[i]);
`ifdef SORT_DESCEND_EN
    q.rsort();
`else
    q.sort();
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; c = 1; seen = 0;
    while (c < 400 && !seen) begin
      if (done) seen = 1;
      else begin
        chk({nm, "_busy"}, busy, 1);
        if (swapxy) chk({nm, "_y_is_x1"}, y, x + 1);
        start = (c == p1 || c == p2);
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    else       chk({nm, "_done_cycle"}, c, exp_cyc);
    chk({nm, "_swap_count"}, swap_count, exp_cnt);
    chk({nm, "_busy_at_done"}, busy, 0);
    bad = 0;
    for (int i = 0; i < NREG; i++) if (regs[i] !== q[i]) bad++;
    chk({nm, "_final_order_bad_slots"}, bad, 0);
    @(negedge clk);
    chk({nm, "_done_pulse_end"}, done, 0);
    chk({nm, "_count_hold"}, swap_count, exp_cnt);
  endtask

  vec_t tbl[5];

  initial begin
    int   mc, my;
    arr_t v;
    string nm;

    // Table: spec vectors plus a start-while-busy replay.
`ifdef SORT_DESCEND_EN
    tbl[0] = '{v: mk(32'h76543210), exp_cnt: 28, exp_cyc: 78, use_model: 0, p1: 0,  p2: 0};
    tbl[1] = '{v: mk(32'h01234567), exp_cnt: 0,  exp_cyc: 8,  use_model: 0, p1: 0,  p2: 0};
    tbl[4] = '{v: mk(32'h76543210), exp_cnt: 28, exp_cyc: 78, use_model: 0, p1: 10, p2: 40};
`else
    tbl[0] = '{v: mk(32'h76543210), exp_cnt: 0,  exp_cyc: 8,  use_model: 0, p1: 0,  p2: 0};
    tbl[1] = '{v: mk(32'h01234567), exp_cnt: 28, exp_cyc: 78, use_model: 0, p1: 0,  p2: 0};
    tbl[4] = '{v: mk(32'h01234567), exp_cnt: 28, exp_cyc: 78, use_model: 0, p1: 10, p2: 40};
`endif
`ifdef SORT_DESCEND_EN
    tbl[2] = '{v: mk(32'h00551133), exp_cnt: 0,  exp_cyc: 0,  use_model: 1, p1: 0,  p2: 0};
`else
    tbl[2] = '{v: mk(32'h00551133), exp_cnt: 16, exp_cyc: 66, use_model: 0, p1: 0,  p2: 0};
`endif
    tbl[3] = '{v: mk(32'h11111111), exp_cnt: 0,  exp_cyc: 8,  use_model: 0, p1: 0,  p2: 0};

    ld_val = mk(32'h0);
    repeat (2) @(negedge clk);
    chk("rst_swapxy", swapxy, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_swap_count", swap_count, 0);
    init_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      mc = tbl[k].exp_cnt; my = tbl[k].exp_cyc;
      if (tbl[k].use_model) model(tbl[k].v, mc, my);
      nm = $sformatf("vec%0d", k);
      run_vec(nm, tbl[k].v, mc, my, tbl[k].p1, tbl[k].p2);
    end

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREG; i++) v[i] = DW'($urandom_range(0, 15));
      model(v, mc, my);
      nm = $sformatf("rnd%0d", k);
      run_vec(nm, v, mc, my, 0, 0);
    end

    // Reset during cycle 20 of a reversed sort, then a fresh full sort.
`ifdef SORT_DESCEND_EN
    load(mk(32'h76543210));
`else
    load(mk(32'h01234567));
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    init_n = 1'b0;
    #1;
    chk("midrst_swapxy", swapxy, 0);
    chk("midrst_x", x, 0);
    chk("midrst_y", y, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_swap_count", swap_count, 0);
    @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);
    v = regs;
    model(v, mc, my);
    run_vec("after_rst", v, mc, my, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
